bank_write_ctrl: RTL and testbench
==================================

Name: bank_write_ctrl

Overview:
- Parametrised multi-bank write controller for the on-chip buffer memory. Generalises the two-bank write controller.
- Packs an incoming word stream into BANK_NUM banks of BANK_DEPTH words each. Banks are filled in round-robin order.
- A bank is handed to the reader when it is filled or when `flush` is asserted. The reader releases it with `r_done`.
- Sits between the input data source and the dual-port RAM write port. The RAM read side is owned by the read controller.

Parameters:
- DATA_W, 8: data word width.
- BANK_NUM, 2: number of banks; power of two, >= 2.
- BANK_DEPTH, 4: words per bank; power of two, >= 2.
- BANK_AW, derived localparam: clog2(BANK_NUM).
- WORD_AW, derived localparam: clog2(BANK_DEPTH).

Ports:
- clk, input, 1: system clock; all state on the rising edge.
- n_rst, input, 1: reset, asynchronous, active-low.
- din, input, DATA_W: write data.
- din_vld, input, 1: din valid for one cycle; accepted only when full=0.
- flush, input, 1: close the current partially filled bank.
- r_done, input, BANK_NUM: one-hot release pulses from the reader; bit i frees bank i.
- full, output, 1: current target bank is occupied; input is not accepted.
- status_vld, output, BANK_NUM: bit i=1 means bank i holds closed data awaiting the reader.
- w_addr, output, BANK_AW+WORD_AW: RAM write address, {bank, offset}.
- w_data, output, DATA_W: RAM write data.
- w_en, output, 1: RAM write strobe.
- bank_done, output, 1: one-cycle pulse when a bank closes.
- done_bank, output, BANK_AW: index of the bank that just closed; valid with bank_done.
- done_len, output, WORD_AW+1: word count of the closed bank (1..BANK_DEPTH); valid with bank_done.
- drop, output, 1: one-cycle pulse when din_vld arrived while full=1.

Behaviour:
- Reset: all outputs 0; cur_bank=0, offset=0, FSM in ST_FILL. Async assert clears everything, including mid-fill; a partially filled bank is discarded.
- Registers: cur_bank (BANK_AW bits), offset (WORD_AW+1 bits), status_vld.
- FSM states:
  - ST_FILL: status_vld[cur_bank]=0.
  - ST_FULL: status_vld[cur_bank]=1.
- full = status_vld[cur_bank], decoded from registers only (no input path). full=1 exactly in ST_FULL.
- Accept condition: din_vld & ~full.
- On accept, next cycle:
  - w_en=1, w_data=din, w_addr={cur_bank, offset[WORD_AW-1:0]}.
  - offset increments.
  - Write latency is 1 cycle; w_* are registered.
- Close on last word: an accepted word with offset==BANK_DEPTH-1 closes the bank.
  - Next cycle: status_vld[cur_bank]=1, bank_done=1, done_bank=cur_bank, done_len=BANK_DEPTH, in the same cycle as that word's w_en.
  - cur_bank advances to (cur_bank+1) mod BANK_NUM; offset returns to 0.
  - If the new cur_bank is still valid, enter ST_FULL.
- flush with offset>0: same close sequence, with done_len=offset.
- flush with offset==0: ignored; no pulse, no advance.
- flush with an accepted din_vld in the same cycle: the word is written and counted first, then the bank closes. done_len=offset+1, and that word's w_en coincides with bank_done.
- flush while full=1: ignored.
- din_vld while full=1: no write; drop=1 for the next cycle; the word is lost.
- r_done[i] with status_vld[i]=1: status_vld[i] clears next cycle. If i==cur_bank, full drops in that cycle and input is accepted from then on (release-to-accept latency 1 cycle).
- r_done[i] with status_vld[i]=0: ignored.
- Multiple r_done bits: all are honoured.
- Same-bank set and clear cannot coincide: a closing bank is never valid, so r_done for it is ignored.
- Allocation is strictly round-robin, so the reader sees banks in write order. A free non-current bank does not clear full.
- w_en, bank_done and drop are pulses. w_addr, w_data, done_bank and done_len hold their last value.

Decomposition:
- Shared package bwc_pkg:
  - FSM state encoding ST_FILL / ST_FULL.
  - clog2 function.
  - Address-concatenation helper.
- The read controller imports bwc_pkg for the same BANK_AW/WORD_AW derivation.
- No sub-module; single flat block.

Test Plan:
All scenarios use defaults DATA_W=8, BANK_NUM=2, BANK_DEPTH=4.
1. Reset held 2 cycles, then released:
   - All outputs 0; full=0.
   - Assert n_rst=0 mid-fill (after 2 writes): all outputs and pointers return to 0 immediately.
2. Write 0x11, 0x22, 0x33, 0x44 back-to-back:
   - w_en for 4 cycles, w_addr 0,1,2,3, w_data matches.
   - With the 4th write: bank_done=1, done_bank=0, done_len=4; next status_vld=2'b01.
3. Write 0x55..0x88:
   - w_addr 4..7; status_vld=2'b11, full=1.
   - din_vld with 0x99: w_en=0, drop=1.
4. r_done=2'b01 for one cycle:
   - Next cycle status_vld=2'b10, full=0.
   - din 0xAA: w_addr=0, w_data=0xAA.
   - r_done=2'b01 again (bank 0 not valid): no change.
5. After 2 more writes, pulse flush:
   - bank_done=1, done_bank=0, done_len=3 (0xAA plus 2 writes); status_vld=2'b11.
   - After r_done=2'b10: flush with offset 0 produces no bank_done.
6. Third word written with din_vld and flush in the same cycle:
   - w_en and bank_done in the same cycle, done_len=3.
   - Last word with flush together: done_len=4, single close.

Source files
------------

// File: rtl/bwc_pkg.sv
// Shared definitions for the bank write controller and its companion read
// controller: FSM encoding, width derivation and RAM address packing.
package bwc_pkg;

  // ST_FILL: current bank is free and accepting words.
  // ST_FULL: current bank still holds closed data awaiting the reader.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } bwc_state_e;

  // Ceiling log2, usable in parameter derivation.
  function automatic int bwc_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // RAM address is {bank, offset}; the caller truncates to its address width.
  function automatic logic [31:0] bwc_addr(input logic [31:0] bank,
                                           input logic [31:0] offset,
                                           input int          word_aw);
    return (bank << word_aw) | offset;
  endfunction

endpackage

// File: rtl/bank_write_ctrl.sv
// Multi-bank write controller: packs a word stream into BANK_NUM banks of
// BANK_DEPTH words, round-robin, handing each closed bank to the reader.
//
// Handshake: a word on din is taken in a cycle where din_vld=1 and full=0;
// it appears on the RAM write port (w_en/w_addr/w_data) one cycle later. A
// din_vld while full=1 is lost and reported by a one-cycle drop pulse. The
// reader frees bank i with a single-cycle pulse on r_done[i].
module bank_write_ctrl
  import bwc_pkg::*;
#(
  parameter int  DATA_W     = 8,
  parameter int  BANK_NUM   = 2,
  parameter int  BANK_DEPTH = 4,
  localparam int BANK_AW    = bwc_clog2(BANK_NUM),
  localparam int WORD_AW    = bwc_clog2(BANK_DEPTH),
  localparam int ADDR_W     = BANK_AW + WORD_AW
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_vld,
  input  logic                flush,
  input  logic [BANK_NUM-1:0] r_done,
  output logic                full,
  output logic [BANK_NUM-1:0] status_vld,
  output logic [ADDR_W-1:0]   w_addr,
  output logic [DATA_W-1:0]   w_data,
  output logic                w_en,
  output logic                bank_done,
  output logic [BANK_AW-1:0]  done_bank,
  output logic [WORD_AW:0]    done_len,
  output logic                drop,
  output bwc_state_e          dbg_state
);

  bwc_state_e          state_q, state_d;
  logic [BANK_AW-1:0]  cur_bank_q, cur_bank_d;
  logic [WORD_AW:0]    offset_q, offset_d;
  logic [BANK_NUM-1:0] status_vld_q, status_vld_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                w_en_q, w_en_d;
  logic                bank_done_q, bank_done_d;
  logic [BANK_AW-1:0]  done_bank_q, done_bank_d;
  logic [WORD_AW:0]    done_len_q, done_len_d;
  logic                drop_q, drop_d;

  logic                full_w;
  logic                accept;
  logic                last_word;
  logic                close;
  logic [WORD_AW:0]    count;
  logic [BANK_NUM-1:0] set_mask;
  logic [BANK_NUM-1:0] clr_mask;

  // Occupancy of the current target bank, from registers only.
  assign full_w = status_vld_q[cur_bank_q];

  // Next-state decode: accept, close, release and output registers.
  always_comb begin
    accept    = din_vld & ~full_w;
    last_word = (offset_q == (WORD_AW+1)'(BANK_DEPTH - 1));
    // An accepted word is counted before a same-cycle flush closes the bank.
    count     = accept ? (offset_q + (WORD_AW+1)'(1)) : offset_q;
    close     = ~full_w & ((accept & last_word) |
                           (flush & (accept | (offset_q != '0))));

    set_mask             = '0;
    set_mask[cur_bank_q] = close;
    // Only valid banks can be released; a closing bank is never valid.
    clr_mask             = r_done & status_vld_q;
    status_vld_d         = (status_vld_q & ~clr_mask) | set_mask;

    cur_bank_d = close ? (cur_bank_q + BANK_AW'(1)) : cur_bank_q;
    offset_d   = close ? '0 : count;
    state_d    = status_vld_d[cur_bank_d] ? ST_FULL : ST_FILL;

    w_en_d   = accept;
    w_data_d = accept ? din : w_data_q;
    w_addr_d = accept ? ADDR_W'(bwc_addr(32'(cur_bank_q),
                                         32'(offset_q[WORD_AW-1:0]), WORD_AW))
                      : w_addr_q;

    bank_done_d = close;
    done_bank_d = close ? cur_bank_q : done_bank_q;
    done_len_d  = close ? count : done_len_q;
    drop_d      = din_vld & full_w;
  end

  // State and registered outputs; async reset discards any partial bank.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_FILL;
      cur_bank_q   <= '0;
      offset_q     <= '0;
      status_vld_q <= '0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      w_en_q       <= 1'b0;
      bank_done_q  <= 1'b0;
      done_bank_q  <= '0;
      done_len_q   <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_bank_q   <= cur_bank_d;
      offset_q     <= offset_d;
      status_vld_q <= status_vld_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      w_en_q       <= w_en_d;
      bank_done_q  <= bank_done_d;
      done_bank_q  <= done_bank_d;
      done_len_q   <= done_len_d;
      drop_q       <= drop_d;
    end
  end

  assign full       = full_w;
  assign status_vld = status_vld_q;
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign w_en       = w_en_q;
  assign bank_done  = bank_done_q;
  assign done_bank  = done_bank_q;
  assign done_len   = done_len_q;
  assign drop       = drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bank_write_ctrl.sv
// Testbench for bank_write_ctrl at default parameters.
module tb_bank_write_ctrl;
  import bwc_pkg::*;

  localparam int BN = 2;
  localparam int BD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    din = '0;
  logic          din_vld = 1'b0;
  logic          flush = 1'b0;
  logic [BN-1:0] r_done = '0;
  logic          full;
  logic [BN-1:0] status_vld;
  logic [2:0]    w_addr;
  logic [7:0]    w_data;
  logic          w_en;
  logic          bank_done;
  logic [0:0]    done_bank;
  logic [2:0]    done_len;
  logic          drop;
  bwc_state_e    dbg_state;

  bank_write_ctrl #(.DATA_W(8), .BANK_NUM(BN), .BANK_DEPTH(BD)) dut (
    .clk(clk), .n_rst(n_rst), .din(din), .din_vld(din_vld), .flush(flush),
    .r_done(r_done), .full(full), .status_vld(status_vld), .w_addr(w_addr),
    .w_data(w_data), .w_en(w_en), .bank_done(bank_done),
    .done_bank(done_bank), .done_len(done_len), .drop(drop),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Banks as a validity array plus a current index and word count.
  bit m_valid [BN];
  int m_cur = 0;
  int m_cnt = 0;

  logic [10:0] exp_wr_q[$];    // {addr, data}
  logic [3:0]  exp_done_q[$];  // {bank, len}
  logic        exp_drop_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < BN; i++) m_valid[i] = 1'b0;
    m_cur = 0;
    m_cnt = 0;
    exp_wr_q.delete();
    exp_done_q.delete();
    exp_drop_q.delete();
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d,
                                     input logic f, input logic [BN-1:0] rd);
    bit was_full;
    bit old_valid [BN];
    was_full = m_valid[m_cur];
    for (int i = 0; i < BN; i++) old_valid[i] = m_valid[i];
    if (v && was_full) exp_drop_q.push_back(1'b1);
    if (v && !was_full) begin
      exp_wr_q.push_back({3'(m_cur * BD + m_cnt), d});
      m_cnt++;
    end
    for (int i = 0; i < BN; i++)
      if (rd[i] && old_valid[i]) m_valid[i] = 1'b0;
    if (!was_full && (m_cnt == BD || (f && m_cnt > 0))) begin
      exp_done_q.push_back({1'(m_cur), 3'(m_cnt)});
      m_valid[m_cur] = 1'b1;
      m_cur = (m_cur + 1) % BN;
      m_cnt = 0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic [7:0] d, input logic f,
                       input logic [BN-1:0] rd);
    din_vld = v;
    din     = d;
    flush   = f;
    r_done  = rd;
    @(posedge clk);
    model_step(v, d, f, rd);
    #1;
    din_vld = 1'b0;
    flush   = 1'b0;
    r_done  = '0;
  endtask

  task automatic wr(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, '0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {full, status_vld, w_addr, w_data, w_en, bank_done,
                 done_bank, done_len, drop, dbg_state}, '0);
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    #2;
    n_rst = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (n_rst) begin
      if (w_en) begin
        if (exp_wr_q.size() == 0) check("unexpected_w_en", 1, 0);
        else check("write_addr_data", {w_addr, w_data}, exp_wr_q.pop_front());
      end
      if (bank_done) begin
        if (exp_done_q.size() == 0) check("unexpected_bank_done", 1, 0);
        else check("done_bank_len", {done_bank, done_len}, exp_done_q.pop_front());
      end
      if (drop) begin
        if (exp_drop_q.size() == 0) check("unexpected_drop", 1, 0);
        else check("drop", drop, exp_drop_q.pop_front());
      end
      check("status_vld", status_vld, {m_valid[1], m_valid[0]});
      check("full", full, m_valid[m_cur]);
      check("dbg_state", dbg_state, m_valid[m_cur] ? ST_FULL : ST_FILL);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    apply_reset();
    @(negedge clk);
    #1;
    check_all_zero("after_reset");

    // Mid-fill async reset: partial bank is discarded immediately.
    wr(8'h01);
    wr(8'h02);
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    check_all_zero("async_reset_midfill");
    apply_reset();

    // Fill bank 0, then bank 1, then a dropped word.
    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    wr(8'h55); wr(8'h66); wr(8'h77); wr(8'h88);
    wr(8'h99);
    cycle(1'b0, 8'h00, 1'b1, '0);           // flush while full: ignored
    @(negedge clk);
    check("both_banks_full", {status_vld, full}, 3'b111);

    // Release bank 0, write, stray release of an invalid bank.
    cycle(1'b0, 8'h00, 1'b0, 2'b01);
    @(negedge clk);
    check("released_full_low", full, 1'b0);
    wr(8'hAA);
    cycle(1'b0, 8'h00, 1'b0, 2'b01);
    wr(8'hBB); wr(8'hCC);
    cycle(1'b0, 8'h00, 1'b1, '0);           // partial flush, len 3
    cycle(1'b0, 8'h00, 1'b0, 2'b10);
    cycle(1'b0, 8'h00, 1'b1, '0);           // flush at offset 0: ignored
    @(negedge clk);
    check("flush_empty_no_close", status_vld, 2'b01);

    // Word and flush together, then last word and flush together.
    cycle(1'b0, 8'h00, 1'b0, 2'b01);
    wr(8'hD1); wr(8'hD2);
    cycle(1'b1, 8'hD3, 1'b1, '0);           // len 3
    cycle(1'b0, 8'h00, 1'b0, 2'b11);
    wr(8'hE1); wr(8'hE2); wr(8'hE3);
    cycle(1'b1, 8'hE4, 1'b1, '0);           // len 4, single close
    repeat (2) cycle(1'b0, 8'h00, 1'b0, '0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      logic [BN-1:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? BN'($urandom_range(0, 3)) : '0;
      cycle($urandom_range(0, 9) < 7, 8'($urandom),
            $urandom_range(0, 9) == 0, rd);
      if (n == 400) begin
        @(negedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check_all_zero("async_reset_random");
        apply_reset();
      end
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b0, '0);
    @(negedge clk);
    #1;
    check("leftover_writes", exp_wr_q.size(), 0);
    check("leftover_done", exp_done_q.size(), 0);
    check("leftover_drop", exp_drop_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
